imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
- Sequences reads of the combinational, word-organised instruction memory on behalf of the core.
- Generates sequential byte addresses and captures each returned word together with its PC in a small prefetch FIFO.
- Presents the FIFO head to the decode stage over a valid/ready handshake.
- Handles control-flow redirects and out-of-range/misaligned fetches, reporting them as faults.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, >=2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- MEM_BYTES, 4096, byte size of the instruction memory; a fetch is legal iff pc <= MEM_BYTES-4.

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- imem_addr_o  out  32  byte address to instruction memory; equals fetch_pc.
- imem_rdata_i  in  32  instruction word returned combinationally for imem_addr_o.
- instr_valid_o  out  1  FIFO head valid.
- instr_ready_i  in  1  decode accepts head when valid && ready.
- instr_o  out  32  head instruction word.
- instr_pc_o  out  32  head PC.
- instr_fault_o  out  1  head entry is a fetch fault; instr_o = 0 for such entries.
- redirect_i  in  1  branch/jump/trap redirect; one-cycle pulse.
- redirect_pc_i  in  32  new fetch address; sampled when redirect_i = 1.
- halted_o  out  1  fetch stopped after a fault, waiting for a redirect.

Behaviour:
- Reset (rst_ni = 0 at an edge):
  - fetch_pc <= RESET_PC; FIFO emptied; state <= RUN.
  - instr_valid_o = 0, instr_o = 0, instr_pc_o = 0, instr_fault_o = 0, halted_o = 0.
  - Reset asserted mid-operation discards all entries on that edge.
- imem_addr_o = fetch_pc at all times, including while halted; memory reads have no side effects.
- FSM states:
  - RUN: issue fetches.
  - HALT: no pushes; halted_o = 1.
- push_ok = (state == RUN) && !redirect_i && (count < DEPTH || pop), where pop = instr_valid_o && instr_ready_i. A simultaneous pop and push on a full FIFO is allowed.
- Push when push_ok:
  - Entry is {pc = fetch_pc, instr = imem_rdata_i, fault = 0}; then fetch_pc <= fetch_pc + 4. Wrap modulo 2^32 is not special-cased because the legality check faults first.
  - If fetch_pc[1:0] != 0 or fetch_pc > MEM_BYTES-4, the entry is {pc = fetch_pc, instr = 0, fault = 1}, fetch_pc is unchanged and state <= HALT.
- Pop: the head advances on valid && ready. Outputs come straight from FIFO registers, with no combinational path from imem_rdata_i to instr_*.
- Latency:
  - A word fetched in cycle N is visible on instr_* in cycle N+1.
  - First instr_valid_o = 1 occurs 2 edges after rst_ni rises: one fetch edge, then the output is visible.
  - Steady state with ready held at 1 delivers 1 instruction per cycle.
- Redirect (redirect_i = 1 at an edge), priority over everything else:
  - FIFO flushed; any pop or push in that cycle is discarded.
  - fetch_pc <= redirect_pc_i; state <= RUN; halted_o <= 0.
  - First redirected fetch occurs in cycle N+1; its instruction is visible in cycle N+2.
  - A misaligned redirect_pc_i produces a fault entry on the next cycle, then HALT.
- Full FIFO without pop: no push, fetch_pc holds.
- Empty FIFO: instr_valid_o = 0; instr_* hold their last values (don't care).
- HALT: the remaining entries, including the fault entry, still drain normally.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr; logic fault;}.
  - fetch_state_t enum {RUN, HALT}.
  - Constant INSTR_BYTES = 4.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t, parameter DEPTH, ports push/pop/flush.
  - Registered head, count output.
  - Flush has priority over push/pop; push is permitted when full if pop is also asserted.

Test Plan:
- Reset, with memory words holding the value of their address; ready = 1 -> instr_valid_o rises on edge 2; instr_pc_o sequence 0x0, 0x4, 0x8… with instr_o matching, one per cycle.
- ready = 0 for 10 cycles after reset -> count saturates at 4; imem_addr_o holds 0x10; on ready = 1, the PCs 0x0–0xC drain, followed by 0x10 with no gap and no duplicate.
- Redirect to 0x100 while the FIFO holds 3 entries -> next cycle instr_valid_o = 0; the following cycle instr_pc_o = 0x100; no old PCs appear afterwards.
- Sequential fetch reaching 0xFFC, then 0x1000 -> entry 0xFFC is normal; entry 0x1000 has fault = 1 and instr = 0; halted_o = 1; imem_addr_o stays 0x1000; redirect to 0x0 clears halted_o and resumes.
- Redirect to 0x102 -> single fault entry with pc = 0x102, then HALT; a simultaneous redirect and pop in the same cycle -> flush wins, with no extra entry.
- rst_ni = 0 for one cycle mid-stream with the FIFO full -> next cycle instr_valid_o = 0 and fetch_pc = RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
// Purpose: prefetch entry layout, fetch FSM states and instruction size.
// Ports: none (package).
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - shift-register prefetch FIFO with a registered head entry
// Purpose: holds fetched entries in order; entry 0 is always the head so the
//   outputs come straight from a register.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   i_flush       : discard all entries (wins over push/pop)
//   i_push/i_data : enqueue an entry (allowed when full if i_pop is also set)
//   i_pop         : dequeue the head (ignored when empty)
//   o_head        : head entry
//   o_valid       : FIFO not empty
//   o_count       : number of stored entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_flush,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  output fetch_entry_t  o_head,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_entries [DEPTH];
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_wr_idx;

  assign w_pop    = i_pop && (r_count != '0);
  assign w_push   = i_push && ((r_count < CW'(DEPTH)) || w_pop);
  // When popping in the same cycle the tail slot moves down by one.
  assign w_wr_idx = w_pop ? (r_count - CW'(1)) : r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) r_entries[i] <= r_entries[i+1];
      end
      // Later assignment overrides the shift for the written slot.
      if (w_push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == w_wr_idx) r_entries[i] <= i_data;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_entries[0];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - sequential instruction fetch with prefetch FIFO and redirect
// Purpose: reads a combinational word memory at fetch_pc, queues {pc, word, fault}
//   entries, hands them to decode over valid/ready, and halts after a fault.
// Ports:
//   clk_i, rst_ni           : clock, synchronous active-low reset
//   imem_addr_o/imem_rdata_i: memory byte address (= fetch_pc) and returned word
//   instr_valid_o/ready_i   : head handshake with decode
//   instr_o/instr_pc_o      : head word and its PC
//   instr_fault_o           : head entry is a fetch fault (word forced to 0)
//   redirect_i/redirect_pc_i: flush and restart fetching at a new PC
//   halted_o                : fetch stopped after a fault
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_fault_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        halted_o
);

  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - INSTR_BYTES);

  fetch_state_t  r_state;
  fetch_state_t  w_state_next;
  logic [31:0]   r_fetch_pc;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_illegal;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;
  logic          w_valid;

  assign w_pop     = w_valid && instr_ready_i;
  assign w_push_ok = (r_state == RUN) && !redirect_i &&
                     ((w_count < CW'(DEPTH)) || w_pop);
  assign w_illegal = (r_fetch_pc[1:0] != 2'b00) || (r_fetch_pc > LAST_PC);

  always_comb begin
    w_entry = '0;
    w_entry.pc = r_fetch_pc;
    if (w_illegal) begin
      w_entry.fault = 1'b1;
    end else begin
      w_entry.instr = imem_rdata_i;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= RUN;
    else         r_state <= w_state_next;
  end

  // Next-state logic: redirect always restarts, a faulting push halts.
  always_comb begin
    w_state_next = r_state;
    if (redirect_i) begin
      w_state_next = RUN;
    end else if (w_push_ok && w_illegal) begin
      w_state_next = HALT;
    end
  end

  // Output logic.
  always_comb begin
    halted_o = (r_state == HALT);
  end

  // A faulting fetch leaves the PC parked on the bad address.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_fetch_pc <= redirect_pc_i;
    end else if (w_push_ok && !w_illegal) begin
      r_fetch_pc <= r_fetch_pc + 32'(INSTR_BYTES);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_flush (redirect_i),
    .i_push  (w_push_ok),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign imem_addr_o   = r_fetch_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_head.instr;
  assign instr_pc_o    = w_head.pc;
  assign instr_fault_o = w_head.fault;

endmodule
